// File: rtl/carfield_uart_tx_driver.sv
// rtl/carfield_uart_tx_driver.sv - UART transmitter with input FIFO driving a carfield uart_rx line
// Frame: start, DataBits LSB-first, optional even parity, 1 or 2 stop bits.
module carfield_uart_tx_driver #(
  parameter int unsigned DataBits    = 8,
  parameter int unsigned FifoDepth   = 4,
  parameter int unsigned ClkDivWidth = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [ClkDivWidth-1:0]       clk_div_i,
  input  logic                         parity_en_i,
  input  logic                         two_stop_i,
  input  logic [DataBits-1:0]          data_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic                         tx_o,
  output logic                         busy_o,
  output logic [$clog2(FifoDepth):0]   usage_o
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned IdxW = $clog2(DataBits);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2
  } state_t;

  logic [DataBits-1:0]    r_mem [FifoDepth];
  logic [PtrW-1:0]        r_wptr, r_rptr;
  logic [PtrW:0]          r_usage;

  state_t                 r_state, w_state_n;
  logic [ClkDivWidth-1:0] r_cnt, w_cnt_n;
  logic [ClkDivWidth-1:0] r_div;
  logic [IdxW-1:0]        r_idx, w_idx_n;
  logic [DataBits-1:0]    r_data;
  logic                   r_par, r_two, r_tx, w_tx_n;

  logic                   w_full, w_empty, w_push, w_pop, w_load, w_bit_end, w_frame_done;
  logic [ClkDivWidth-1:0] w_div_in;
  logic [IdxW-1:0]        w_idx_inc;
  logic [DataBits-1:0]    w_head;

  assign w_full    = (r_usage == (PtrW+1)'(FifoDepth));
  assign w_empty   = (r_usage == '0);
  assign w_push    = valid_i & ~w_full;
  assign w_head    = r_mem[r_rptr];
  assign w_div_in  = (clk_div_i == '0) ? ClkDivWidth'(1) : clk_div_i;
  assign w_bit_end = (r_cnt == '0);
  assign w_idx_inc = r_idx + IdxW'(1);

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_usage <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_usage <= r_usage + (PtrW+1)'(1);
        2'b01:   r_usage <= r_usage - (PtrW+1)'(1);
        default: r_usage <= r_usage;
      endcase
    end
  end

  // Every bit lasts r_div cycles: the counter reloads with div-1 and the state moves on at 0.
  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = (r_state == IDLE) ? r_cnt : r_cnt - ClkDivWidth'(1);
    w_idx_n      = r_idx;
    w_tx_n       = r_tx;
    w_pop        = 1'b0;
    w_load       = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_load    = 1'b1;
          w_tx_n    = 1'b0;
          w_cnt_n   = w_div_in - ClkDivWidth'(1);
          w_state_n = START;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_n = DATA;
          w_idx_n   = '0;
          w_tx_n    = r_data[0];
          w_cnt_n   = r_div - ClkDivWidth'(1);
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_cnt_n = r_div - ClkDivWidth'(1);
          if (r_idx == IdxW'(DataBits - 1)) begin
            w_state_n = r_par ? PARITY : STOP1;
            w_tx_n    = r_par ? ^r_data : 1'b1;
          end else begin
            w_idx_n = w_idx_inc;
            w_tx_n  = r_data[w_idx_inc];
          end
        end
      end
      PARITY: begin
        if (w_bit_end) begin
          w_state_n = STOP1;
          w_tx_n    = 1'b1;
          w_cnt_n   = r_div - ClkDivWidth'(1);
        end
      end
      STOP1: begin
        if (w_bit_end) begin
          if (r_two) begin
            w_state_n = STOP2;
            w_cnt_n   = r_div - ClkDivWidth'(1);
          end else begin
            w_frame_done = 1'b1;
          end
        end
      end
      STOP2: begin
        if (w_bit_end) w_frame_done = 1'b1;
      end
      default: w_state_n = IDLE;
    endcase
    // A queued byte starts immediately after the last stop bit, with no idle gap.
    if (w_frame_done) begin
      if (!w_empty) begin
        w_pop     = 1'b1;
        w_load    = 1'b1;
        w_tx_n    = 1'b0;
        w_cnt_n   = w_div_in - ClkDivWidth'(1);
        w_state_n = START;
      end else begin
        w_tx_n    = 1'b1;
        w_state_n = IDLE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_tx    <= 1'b1;
      r_data  <= '0;
      r_div   <= ClkDivWidth'(1);
      r_par   <= 1'b0;
      r_two   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_idx   <= w_idx_n;
      r_tx    <= w_tx_n;
      if (w_load) begin
        r_data <= w_head;
        r_div  <= w_div_in;
        r_par  <= parity_en_i;
        r_two  <= two_stop_i;
      end
    end
  end

  assign ready_o = ~w_full;
  assign tx_o    = r_tx;
  assign busy_o  = (r_state != IDLE) | ~w_empty;
  assign usage_o = r_usage;

endmodule

// File: tb/tb_carfield_uart_tx_driver.sv
// tb/tb_carfield_uart_tx_driver.sv - scoreboard testbench for carfield_uart_tx_driver
module tb_carfield_uart_tx_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] clk_div_i = 16'd1;
  logic        parity_en_i = 1'b0;
  logic        two_stop_i = 1'b0;
  logic [7:0]  data_i = 8'h00;
  logic        valid_i = 1'b0;
  logic        ready_o, tx_o, busy_o;
  logic [2:0]  usage_o;

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         par;
    bit         two;
  } frame_t;

  frame_t exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  carfield_uart_tx_driver #(
    .DataBits(8), .FifoDepth(4), .ClkDivWidth(16)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .clk_div_i(clk_div_i),
    .parity_en_i(parity_en_i), .two_stop_i(two_stop_i),
    .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .tx_o(tx_o), .busy_o(busy_o), .usage_o(usage_o)
  );

  function automatic frame_t make_frame(input logic [7:0] b);
    frame_t f;
    f.data = b;
    f.div  = (clk_div_i == 16'd0) ? 1 : int'(clk_div_i);
    f.par  = parity_en_i;
    f.two  = two_stop_i;
    return f;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    exp_q.push_back(make_frame(b));
    valid_i = 1'b1;
    data_i  = b;
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  // Waits for a start bit, then compares every sampled cycle of the frame against the popped expectation.
  task automatic check_frame(input int max_wait, output int waited);
    frame_t f;
    logic   bits[$];
    int     bad, first_bad;
    logic   obs_bad, exp_bad, expv;
    waited = 0;
    while (1) begin
      @(negedge clk);
      if (tx_o === 1'b0) break;
      waited++;
      if (waited > max_wait) begin
        checks++; errors++;
        $display("FAIL frame_start: no start bit within %0d cycles, tx_o=%b, required 0", max_wait, tx_o);
        return;
      end
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL frame_unexpected: start bit observed, required no frame");
      return;
    end
    f = exp_q.pop_front();
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(f.data[i]);
    if (f.par) bits.push_back(^f.data);
    bits.push_back(1'b1);
    if (f.two) bits.push_back(1'b1);
    bad = 0; first_bad = -1; obs_bad = 1'b0; exp_bad = 1'b0;
    for (int k = 1; k < bits.size() * f.div; k++) begin
      @(negedge clk);
      expv = bits[k / f.div];
      if (tx_o !== expv) begin
        if (bad == 0) begin
          first_bad = k; obs_bad = tx_o; exp_bad = expv;
        end
        bad++;
      end
    end
    if (bad != 0) begin
      errors++;
      $display("FAIL frame_0x%02h: %0d bad cycles, first at cycle %0d tx_o=%b required %b",
               f.data, bad, first_bad, obs_bad, exp_bad);
    end
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || tx_o !== 1'b1) begin
      errors++;
      $display("FAIL %s: busy_o=%b tx_o=%b, required busy_o=0 tx_o=1", name, busy_o, tx_o);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (tx_o !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b required 1", tx_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy_o); end
    checks++; if (usage_o !== 3'd0) begin errors++; $display("FAIL reset_usage: got %0d required 0", usage_o); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_frame();
    int w;
    clk_div_i = 16'd4; parity_en_i = 1'b0; two_stop_i = 1'b0;
    fork
      push_byte(8'h55);
      check_frame(4, w);
    join
    checks++;
    if (w !== 1) begin
      errors++;
      $display("FAIL latency: start bit after %0d idle samples, required 1", w);
    end
    check_idle("basic_busy_after");
  endtask

  task automatic test_back_to_back();
    int w0, w1;
    clk_div_i = 16'd2; parity_en_i = 1'b1; two_stop_i = 1'b0;
    fork
      begin push_byte(8'hA5); push_byte(8'h01); end
      begin check_frame(4, w0); check_frame(0, w1); end
    join
    check_idle("b2b_busy_after");
  endtask

  task automatic test_two_stop();
    int w;
    clk_div_i = 16'd1; parity_en_i = 1'b0; two_stop_i = 1'b1;
    fork
      push_byte(8'hFF);
      check_frame(4, w);
    join
    check_idle("two_stop_busy_after");
  endtask

  task automatic test_fifo_full();
    logic [7:0] b[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    clk_div_i = 16'd8; parity_en_i = 1'b0; two_stop_i = 1'b0;
    fork
      begin
        int  acc = 0;
        int  guard = 0;
        logic r;
        valid_i = 1'b1; data_i = b[0];
        while (acc < 6 && guard < 2000) begin
          r = ready_o;
          @(negedge clk);
          guard++;
          if (r) begin
            exp_q.push_back(make_frame(b[acc]));
            acc++;
            if (acc == 5) begin
              checks++;
              if (ready_o !== 1'b0) begin errors++; $display("FAIL full_ready: got %b required 0", ready_o); end
              checks++;
              if (usage_o !== 3'd4) begin errors++; $display("FAIL full_usage: got %0d required 4", usage_o); end
            end
            if (acc < 6) data_i = b[acc];
          end
        end
        valid_i = 1'b0;
        checks++;
        if (acc != 6) begin errors++; $display("FAIL full_accept: accepted %0d required 6", acc); end
      end
      begin
        int w;
        check_frame(4, w);
        for (int i = 0; i < 5; i++) check_frame(0, w);
      end
    join
    check_idle("full_busy_after");
  endtask

  task automatic test_div_zero();
    int w;
    clk_div_i = 16'd0; parity_en_i = 1'b0; two_stop_i = 1'b0;
    fork
      push_byte(8'h0F);
      begin repeat (4) @(negedge clk); clk_div_i = 16'd5; end
      check_frame(4, w);
    join
    check_idle("div_zero_busy_after");
  endtask

  task automatic test_reset_mid_frame();
    int noisy = 0;
    clk_div_i = 16'd4; parity_en_i = 1'b0; two_stop_i = 1'b0;
    push_byte(8'h00); push_byte(8'h00); push_byte(8'h00);
    repeat (4) @(negedge clk);
    checks++;
    if (tx_o !== 1'b0 || usage_o !== 3'd2) begin
      errors++;
      $display("FAIL mid_frame_state: tx_o=%b usage_o=%0d, required tx_o=0 usage_o=2", tx_o, usage_o);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (tx_o !== 1'b1) begin errors++; $display("FAIL abort_tx: got %b required 1", tx_o); end
    checks++; if (usage_o !== 3'd0) begin errors++; $display("FAIL abort_usage: got %0d required 0", usage_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b required 0", busy_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b required 1", ready_o); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_o !== 1'b1 || busy_o !== 1'b0) noisy++;
    end
    checks++;
    if (noisy != 0) begin
      errors++;
      $display("FAIL abort_quiet: %0d active cycles after release, required 0", noisy);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_two_stop();
    test_fifo_full();
    test_div_zero();
    test_reset_mid_frame();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d frames left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
